// File: rtl/pc_fetch.sv
// pc_fetch: instruction-fetch front end of the MIPS pipeline.
//
// Generates the program counter, runs a single-outstanding req/ack
// transaction with instruction memory, and buffers up to two returned words
// (head + skid). The head is presented to the IF/ID register. Branches from
// ID redirect with delay-slot semantics; flushes redirect and empty the queue.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_stall                  IF/ID hold from ctrl (0 = IF/ID captures head)
//   i_branch, i_branch_pc    taken-branch redirect from ID (ignored while stalled)
//   i_flush, i_flush_pc      exception/flush redirect (beats branch, ignores stall)
//   o_imem_req, o_imem_addr  memory transaction active / word address
//   i_imem_ack, i_imem_rdata one-cycle transaction end / instruction word
//   o_if_pc, o_if_inst       head entry (0 / NOP when empty)
//   o_if_valid, o_stallreq   head present / request a pipeline stall
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    input  logic        i_branch,
    input  logic [31:0] i_branch_pc,
    input  logic        i_flush,
    input  logic [31:0] i_flush_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_if_pc,
    output logic [31:0] o_if_inst,
    output logic        o_if_valid,
    output logic        o_stallreq
);

    logic [31:0] fetchPc_q, fetchPc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic        drop_q, drop_d;

    logic        headValid_q, headValid_d;
    logic [31:0] headPc_q, headPc_d;
    logic [31:0] headInst_q, headInst_d;
    logic        skidValid_q, skidValid_d;
    logic [31:0] skidPc_q, skidPc_d;
    logic [31:0] skidInst_q, skidInst_d;

    logic        consume;
    logic        takeBranch;
    logic        redirect;
    logic        ack;
    logic        capture;
    logic        issue;
    logic [31:0] redirectPc;
    logic [31:0] basePc;
    logic [1:0]  occAfter;

    always_comb begin
        consume    = headValid_q && !i_stall && !i_flush;
        takeBranch = i_branch && !i_stall && !i_flush;
        redirect   = i_flush || takeBranch;
        // Acks outside a transaction (e.g. one left over from before reset)
        // carry no meaning and are ignored.
        ack        = req_q && i_imem_ack;
        capture    = ack && !drop_q && !redirect;
        redirectPc = (i_flush ? i_flush_pc : i_branch_pc) & ~32'h3;
        basePc     = redirect ? redirectPc : fetchPc_q;
    end

    // Queue update. A redirect empties the queue; on a branch the head being
    // consumed is the delay slot, everything younger is wrong-path. A capture
    // can never land on a full queue because a transaction is only issued
    // when at most one entry will remain.
    always_comb begin
        headValid_d = headValid_q;
        headPc_d    = headPc_q;
        headInst_d  = headInst_q;
        skidValid_d = skidValid_q;
        skidPc_d    = skidPc_q;
        skidInst_d  = skidInst_q;

        if (redirect) begin
            headValid_d = 1'b0;
            skidValid_d = 1'b0;
        end else begin
            if (consume) begin
                headValid_d = skidValid_q;
                headPc_d    = skidPc_q;
                headInst_d  = skidInst_q;
                skidValid_d = 1'b0;
            end
            if (capture) begin
                if (!headValid_d) begin
                    headValid_d = 1'b1;
                    headPc_d    = addr_q;
                    headInst_d  = i_imem_rdata;
                end else begin
                    skidValid_d = 1'b1;
                    skidPc_d    = addr_q;
                    skidInst_d  = i_imem_rdata;
                end
            end
        end
    end

    // Transaction control. Only one transaction is ever outstanding; when a
    // redirect hits one that is still waiting, it runs to completion with
    // drop set so its data is thrown away.
    always_comb begin
        occAfter  = {1'b0, headValid_d} + {1'b0, skidValid_d};
        issue     = (!req_q || ack) && (occAfter <= 2'd1);

        addr_d    = addr_q;
        req_d     = req_q && !ack;
        fetchPc_d = basePc;
        if (issue) begin
            addr_d    = basePc;
            req_d     = 1'b1;
            fetchPc_d = basePc + 32'd4;
        end

        drop_d = drop_q;
        if (req_q && !ack && redirect) begin
            drop_d = 1'b1;
        end else if (ack) begin
            drop_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetchPc_q   <= RESET_PC & ~32'h3;
            req_q       <= 1'b0;
            addr_q      <= 32'h0;
            drop_q      <= 1'b0;
            headValid_q <= 1'b0;
            headPc_q    <= 32'h0;
            headInst_q  <= 32'h0;
            skidValid_q <= 1'b0;
            skidPc_q    <= 32'h0;
            skidInst_q  <= 32'h0;
        end else begin
            fetchPc_q   <= fetchPc_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            drop_q      <= drop_d;
            headValid_q <= headValid_d;
            headPc_q    <= headPc_d;
            headInst_q  <= headInst_d;
            skidValid_q <= skidValid_d;
            skidPc_q    <= skidPc_d;
            skidInst_q  <= skidInst_d;
        end
    end

    always_comb begin
        o_imem_req  = req_q;
        o_imem_addr = addr_q;
        o_if_valid  = headValid_q;
        o_stallreq  = !headValid_q;
        o_if_pc     = headValid_q ? headPc_q : 32'h0;
        o_if_inst   = headValid_q ? headInst_q : 32'h0;
    end

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: self-checking bench for pc_fetch.
//
// A behavioural memory answers each request after a random latency with a
// word derived from its address. The reference model is the architectural
// instruction stream: the next expected PC advances by 4 per delivered word
// and jumps to the target after a branch's delay slot or on a flush. Every
// word IF/ID takes must match that stream.
module tb_pc_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        i_stall;
    logic        i_branch;
    logic [31:0] i_branch_pc;
    logic        i_flush;
    logic [31:0] i_flush_pc;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_rdata;
    logic [31:0] o_if_pc;
    logic [31:0] o_if_inst;
    logic        o_if_valid;
    logic        o_stallreq;

    int          vectorCount = 0;
    int          missCount   = 0;
    int          consumedCount = 0;

    logic [31:0] expPc;
    bit          memBusy;
    int          memLeft;
    logic [31:0] memAddr;
    int          memLo;
    int          memHi;

    pc_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_stall      (i_stall),
        .i_branch     (i_branch),
        .i_branch_pc  (i_branch_pc),
        .i_flush      (i_flush),
        .i_flush_pc   (i_flush_pc),
        .o_imem_req   (o_imem_req),
        .o_imem_addr  (o_imem_addr),
        .i_imem_ack   (i_imem_ack),
        .i_imem_rdata (i_imem_rdata),
        .o_if_pc      (o_if_pc),
        .o_if_inst    (o_if_inst),
        .o_if_valid   (o_if_valid),
        .o_stallreq   (o_stallreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instOf(input logic [31:0] addr);
        return {addr[15:0], addr[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Hold reset for two edges, check the reset state, then release. Returns
    // at a falling edge in the first cycle after reset.
    task automatic doReset();
        rst        = 1'b1;
        i_stall    = 1'b0;
        i_branch   = 1'b0;
        i_flush    = 1'b0;
        i_imem_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rstValid", {31'h0, o_if_valid}, 32'h0);
        checkOutput("rstStallreq", {31'h0, o_stallreq}, 32'h1);
        checkOutput("rstPc", o_if_pc, 32'h0);
        checkOutput("rstInst", o_if_inst, 32'h0);
        checkOutput("rstReq", {31'h0, o_imem_req}, 32'h0);
        checkOutput("rstAddr", o_imem_addr, 32'h0);
        rst     = 1'b0;
        memBusy = 1'b0;
        expPc   = RESET_PC & ~32'h3;
    endtask

    // One clock cycle: answer memory, check the word IF/ID takes against the
    // architectural stream, advance the stream, then step to the next
    // falling edge.
    task automatic applyStimulus(input bit stall, input bit br, input logic [31:0] bpc,
                                 input bit fl, input logic [31:0] fpc);
        i_stall     = stall;
        i_branch    = br;
        i_branch_pc = bpc;
        i_flush     = fl;
        i_flush_pc  = fpc;

        checkOutput("stallreq", {31'h0, o_stallreq}, {31'h0, !o_if_valid});
        if (!o_if_valid) begin
            checkOutput("emptyPc", o_if_pc, 32'h0);
            checkOutput("emptyInst", o_if_inst, 32'h0);
        end

        i_imem_ack   = 1'b0;
        i_imem_rdata = $urandom;
        if (o_imem_req) begin
            if (!memBusy) begin
                memBusy = 1'b1;
                memAddr = o_imem_addr;
                memLeft = $urandom_range(memHi, memLo);
            end else begin
                checkOutput("addrHold", o_imem_addr, memAddr);
            end
            if (memLeft == 0) begin
                i_imem_ack   = 1'b1;
                i_imem_rdata = instOf(memAddr);
                memBusy      = 1'b0;
            end else begin
                memLeft--;
            end
        end

        if (o_if_valid && !stall && !fl) begin
            checkOutput("ifPc", o_if_pc, expPc);
            checkOutput("ifInst", o_if_inst, instOf(expPc));
            expPc = expPc + 32'd4;
            consumedCount++;
        end
        if (fl) begin
            expPc = fpc & ~32'h3;
        end else if (br && !stall) begin
            expPc = bpc & ~32'h3;
        end

        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        rst          = 1'b1;
        i_stall      = 1'b0;
        i_branch     = 1'b0;
        i_branch_pc  = 32'h0;
        i_flush      = 1'b0;
        i_flush_pc   = 32'h0;
        i_imem_ack   = 1'b0;
        i_imem_rdata = 32'h0;
        memBusy      = 1'b0;
        memLeft      = 0;
        memAddr      = 32'h0;
        expPc        = RESET_PC;

        // Zero-wait stream.
        memLo = 0;
        memHi = 0;
        doReset();
        checkOutput("firstReq", {31'h0, o_imem_req}, 32'h0);
        idle(1);
        checkOutput("secondReq", {31'h0, o_imem_req}, 32'h1);
        checkOutput("secondAddr", o_imem_addr, RESET_PC);
        checkOutput("secondValid", {31'h0, o_if_valid}, 32'h0);
        idle(1);
        for (int k = 0; k < 4; k++) begin
            checkOutput("streamValid", {31'h0, o_if_valid}, 32'h1);
            checkOutput("streamPc", o_if_pc, 32'(k * 4));
            idle(1);
        end

        // Backpressure.
        doReset();
        for (int k = 0; k < 6; k++) begin
            checkOutput("bpAddrNot12", {31'h0, o_imem_addr == 32'd12}, 32'h0);
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        end
        checkOutput("bpReqLow", {31'h0, o_imem_req}, 32'h0);
        checkOutput("bpHeadPc", o_if_pc, 32'h0);
        idle(1);
        checkOutput("bpPc4", o_if_pc, 32'h4);
        idle(1);
        checkOutput("bpPc8", o_if_pc, 32'h8);
        idle(3);

        // Flush while memory waits 3 cycles.
        memLo = 3;
        memHi = 3;
        doReset();
        idle(1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h180);
        checkOutput("flValid", {31'h0, o_if_valid}, 32'h0);
        checkOutput("flReqHeld", {31'h0, o_imem_req}, 32'h1);
        checkOutput("flAddrHeld", o_imem_addr, 32'h0);
        for (int k = 0; k < 8 && o_imem_addr == 32'h0; k++) idle(1);
        checkOutput("flNextAddr", o_imem_addr, 32'h180);
        idle(10);

        // Flush, branch and ack in the same cycle: flush wins.
        memLo = 0;
        memHi = 0;
        doReset();
        idle(4);
        applyStimulus(1'b0, 1'b1, 32'h200, 1'b1, 32'h300);
        checkOutput("fbValid", {31'h0, o_if_valid}, 32'h0);
        checkOutput("fbReq", {31'h0, o_imem_req}, 32'h1);
        checkOutput("fbAddr", o_imem_addr, 32'h300);
        idle(4);

        // Address wrap.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8);
        checkOutput("wrapAddr", o_imem_addr, 32'hFFFF_FFF8);
        idle(1);
        checkOutput("wrapPc0", o_if_pc, 32'hFFFF_FFF8);
        idle(1);
        checkOutput("wrapPc1", o_if_pc, 32'hFFFF_FFFC);
        idle(1);
        checkOutput("wrapPc2", o_if_pc, 32'h0000_0000);
        idle(2);

        // Random traffic.
        memLo = 0;
        memHi = 3;
        consumedCount = 0;
        for (int k = 0; k < 3000; k++) begin
            bit          stall;
            bit          br;
            bit          fl;
            logic [31:0] bpc;
            logic [31:0] fpc;
            if (k == 1500) doReset();
            stall = ($urandom_range(99, 0) < 30);
            br    = ($urandom_range(99, 0) < 10);
            fl    = ($urandom_range(99, 0) < 3);
            bpc   = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                                 : 32'($urandom);
            fpc   = 32'($urandom);
            applyStimulus(stall, br, bpc, fl, fpc);
        end
        checkOutput("progress", {31'h0, consumedCount >= 300}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
